// File: rtl/prism_pkg.sv
// Shared types and constants for the prism scene sequencer.
package prism_pkg;

    // Width of the animation phase accumulator (wraps mod 1024).
    localparam int PHASE_W = 10;

    // Full-brightness fade level; 0 is black.
    localparam logic [2:0] FADE_MAX = 3'd7;

    // Scene scheduling states.
    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        FADE_OUT = 2'd1,
        SWITCH   = 2'd2,
        FADE_IN  = 2'd3
    } state_t;

endpackage

// File: rtl/prism_frame_tick.sv
// Vsync polarity fix, vsync/step edge detection and frame-advance strobe.
module prism_frame_tick #(
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic vsync,
    input  logic pause,
    input  logic step,
    output logic frame_tick,
    output logic adv
);

    logic vs_act;
    logic vs_act_q;
    logic step_q;
    logic tick;
    logic step_rise;

    assign vs_act    = vsync ^ VSYNC_ACTIVE_LOW;
    assign tick      = vs_act & ~vs_act_q;
    assign step_rise = step & ~step_q;

    // A step edge landing on a tick while paused still yields a single advance,
    // because only the step term is enabled while paused.
    assign adv = (tick & ~pause) | (step_rise & pause);

    // Edge-detect history and the registered frame pulse.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values,
        // independent of statement order inside the block.
        if (reset) begin
            vs_act_q   <= 1'b0;
            step_q     <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            vs_act_q   <= vs_act;
            step_q     <= step;
            frame_tick <= tick;
        end
    end

endmodule

// File: rtl/prism_scene_sequencer.sv
// Frame-rate controller: animation phase, timed/manual scene scheduling and
// crossfade level for the prism VGA demo. Single clock domain.
module prism_scene_sequencer
    import prism_pkg::*;
#(
    parameter int NUM_SCENES       = 3,
    parameter int SCENE_FRAMES     = 240,
    parameter int FADE_DIV         = 4,
    parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               pause,
    input  logic               step,
    input  logic [1:0]         speed,
    input  logic               reverse,
    input  logic               auto_cycle,
    input  logic [1:0]         scene_sel,
    output logic               frame_tick,
    output logic [PHASE_W-1:0] phase,
    output logic [1:0]         scene,
    output logic [2:0]         fade,
    output logic               scene_changed
);

    localparam int DWELL_W = (SCENE_FRAMES > 1) ? $clog2(SCENE_FRAMES) : 1;
    localparam int DIV_W   = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [1:0] LAST_SCENE = 2'(NUM_SCENES - 1);

    state_t             state;
    state_t             state_next;
    logic               adv;
    logic [DWELL_W-1:0] dwell;
    logic [DIV_W-1:0]   div_cnt;
    logic [1:0]         target;
    logic [1:0]         target_in;
    logic [1:0]         next_scene;
    logic [PHASE_W-1:0] phase_inc;
    logic               sel_valid;
    logic               dwell_done;
    logic               div_done;
    logic               fade_step;
    logic               load_target;
    logic               fade_dec;
    logic               fade_inc;
    logic               do_switch;

    prism_frame_tick #(
        .VSYNC_ACTIVE_LOW(VSYNC_ACTIVE_LOW)
    ) u_frame_tick (
        .clk        (clk),
        .reset      (reset),
        .vsync      (vsync),
        .pause      (pause),
        .step       (step),
        .frame_tick (frame_tick),
        .adv        (adv)
    );

    assign phase_inc  = PHASE_W'(1) << speed;
    assign sel_valid  = int'(scene_sel) < NUM_SCENES;
    assign dwell_done = (dwell == DWELL_W'(SCENE_FRAMES - 1));
    assign div_done   = (div_cnt == DIV_W'(FADE_DIV - 1));
    assign fade_step  = adv & div_done;
    assign next_scene = (scene == LAST_SCENE) ? 2'd0 : scene + 2'd1;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= HOLD;
        else       state <= state_next;
    end

    // Next-state logic; SWITCH is the only state that moves without an advance.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_next unassigned,
        // which would otherwise infer a latch.
        state_next = state;
        case (state)
            HOLD: begin
                if (adv) begin
                    if (auto_cycle) begin
                        if (dwell_done) state_next = FADE_OUT;
                    end else if (sel_valid && (scene_sel != scene)) begin
                        state_next = FADE_OUT;
                    end
                end
            end
            FADE_OUT: if (fade_step && (fade == 3'd1))           state_next = SWITCH;
            SWITCH:                                               state_next = FADE_IN;
            FADE_IN:  if (fade_step && (fade == FADE_MAX - 3'd1)) state_next = HOLD;
            default:                                              state_next = HOLD;
        endcase
    end

    // Per-state control strobes for the datapath.
    always_comb begin
        load_target = (state == HOLD) && (state_next == FADE_OUT);
        fade_dec    = (state == FADE_OUT) && fade_step;
        fade_inc    = (state == FADE_IN) && fade_step;
        do_switch   = (state == SWITCH);
        target_in   = auto_cycle ? next_scene : scene_sel;
    end

    // Phase accumulator, dwell/fade counters, scene and target registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            phase         <= '0;
            scene         <= 2'd0;
            fade          <= FADE_MAX;
            dwell         <= '0;
            div_cnt       <= '0;
            target        <= 2'd0;
            scene_changed <= 1'b0;
        end else begin
            if (adv) begin
                phase <= reverse ? (phase - phase_inc) : (phase + phase_inc);
            end

            // Dwell only counts in timed HOLD; leaving auto mode clears it.
            if ((state != HOLD) || !auto_cycle || load_target) begin
                dwell <= '0;
            end else if (adv) begin
                dwell <= dwell + DWELL_W'(1);
            end

            // The fade divider restarts on every state entry.
            if (state_next != state) begin
                div_cnt <= '0;
            end else if (adv && ((state == FADE_OUT) || (state == FADE_IN))) begin
                div_cnt <= div_done ? '0 : div_cnt + DIV_W'(1);
            end

            if (load_target) target <= target_in;
            if (fade_dec)    fade   <= fade - 3'd1;
            if (fade_inc)    fade   <= fade + 3'd1;
            if (do_switch)   scene  <= target;

            scene_changed <= do_switch;
        end
    end

endmodule

// File: tb/tb_prism_scene_sequencer.sv
// Directed self-checking bench for prism_scene_sequencer (short dwell, no fade divider).
module tb_prism_scene_sequencer;
    import prism_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic       pause;
    logic       step;
    logic [1:0] speed;
    logic       reverse;
    logic       auto_cycle;
    logic [1:0] scene_sel;
    logic       frame_tick;
    logic [9:0] phase;
    logic [1:0] scene;
    logic [2:0] fade;
    logic       scene_changed;

    int total = 0;
    int bad   = 0;
    int tick_cnt = 0;
    int sc_cnt   = 0;

    prism_scene_sequencer #(
        .NUM_SCENES       (3),
        .SCENE_FRAMES     (4),
        .FADE_DIV         (1),
        .VSYNC_ACTIVE_LOW (1'b1)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .vsync         (vsync),
        .pause         (pause),
        .step          (step),
        .speed         (speed),
        .reverse       (reverse),
        .auto_cycle    (auto_cycle),
        .scene_sel     (scene_sel),
        .frame_tick    (frame_tick),
        .phase         (phase),
        .scene         (scene),
        .fade          (fade),
        .scene_changed (scene_changed)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_tick === 1'b1)    tick_cnt++;
        if (scene_changed === 1'b1) sc_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // One active-low vsync pulse; returns on a falling clock edge once settled.
    task automatic frame();
        @(negedge clk) vsync = 1'b0;
        @(negedge clk) vsync = 1'b1;
        @(negedge clk);
    endtask

    // Full timed rotation: 4 held frames, 7 fade-out frames, switch, 7 fade-in frames.
    task automatic auto_rotate(input logic [1:0] exp_scene);
        repeat (3) frame();
        check("auto_still_hold", dut.state, HOLD);
        frame();
        check("auto_fade_out", dut.state, FADE_OUT);
        check("auto_target", dut.target, exp_scene);
        for (int i = 6; i >= 0; i--) begin
            frame();
            check("auto_fade_dn", fade, i);
        end
        check("auto_scene", scene, exp_scene);
        check("auto_changed_hi", scene_changed, 1);
        check("auto_fade_in", dut.state, FADE_IN);
        @(negedge clk);
        check("auto_changed_lo", scene_changed, 0);
        for (int i = 1; i <= 7; i++) begin
            frame();
            check("auto_fade_up", fade, i);
        end
        check("auto_back_hold", dut.state, HOLD);
    endtask

    initial begin
        reset = 1'b1; vsync = 1'b1; pause = 1'b0; step = 1'b0;
        speed = 2'd0; reverse = 1'b0; auto_cycle = 1'b0; scene_sel = 2'd0;
        repeat (3) @(negedge clk);
        check("rst_phase", phase, 0);
        check("rst_scene", scene, 0);
        check("rst_fade", fade, 7);
        check("rst_state", dut.state, HOLD);
        check("rst_ftick", frame_tick, 0);
        check("rst_changed", scene_changed, 0);
        reset = 1'b0;

        // Three frames at speed 0.
        repeat (3) frame();
        check("tick_count", tick_cnt, 3);
        check("phase_3", phase, 3);
        check("scene_0", scene, 0);
        check("fade_7", fade, 7);

        // Reverse through zero: 3,2,1,0,1023,1022.
        reverse = 1'b1;
        repeat (4) frame();
        check("phase_wrap_dn", phase, 1023);
        frame();
        check("phase_1022", phase, 1022);
        speed = 2'd1; reverse = 1'b0;
        frame();
        check("phase_wrap_up", phase, 0);
        reverse = 1'b1;
        frame();
        check("phase_back_1022", phase, 1022);
        speed = 2'd3; reverse = 1'b0;
        frame();
        check("phase_speed3", phase, 6);
        speed = 2'd2; reverse = 1'b1;
        frame();
        check("phase_speed2_rev", phase, 2);

        // Pause freezes phase; step edge on the tick cycle advances once.
        speed = 2'd0; reverse = 1'b0; pause = 1'b1;
        repeat (5) frame();
        check("pause_hold", phase, 2);
        @(negedge clk) begin vsync = 1'b0; step = 1'b1; end
        @(negedge clk) vsync = 1'b1;
        @(negedge clk) step = 1'b0;
        @(negedge clk);
        check("step_with_tick", phase, 3);
        @(negedge clk) step = 1'b1;
        @(negedge clk) step = 1'b0;
        @(negedge clk);
        check("step_alone", phase, 4);
        pause = 1'b0;

        // Timed rotation 0->1->2->0.
        auto_cycle = 1'b1;
        auto_rotate(2'd1);
        auto_rotate(2'd2);
        auto_rotate(2'd0);
        check("changed_count_auto", sc_cnt, 3);

        // Leaving auto mode in HOLD clears dwell.
        repeat (2) frame();
        check("dwell_2", dut.dwell, 2);
        auto_cycle = 1'b0; scene_sel = 2'd0;
        @(negedge clk);
        check("dwell_cleared", dut.dwell, 0);

        // Manual request for scene 2; mid-fade change to 1 is deferred.
        scene_sel = 2'd2;
        frame();
        check("man_fade_out", dut.state, FADE_OUT);
        check("man_target_2", dut.target, 2);
        repeat (3) frame();
        check("man_fade_4", fade, 4);
        scene_sel = 2'd1;
        repeat (4) frame();
        check("man_scene_2", scene, 2);
        repeat (7) frame();
        check("man_hold_2", dut.state, HOLD);
        check("man_fade_full", fade, 7);
        frame();
        check("man_target_1", dut.target, 1);
        repeat (14) frame();
        check("man_scene_1", scene, 1);
        check("man_hold_1", dut.state, HOLD);
        scene_sel = 2'd3;
        frame();
        check("bad_sel_state", dut.state, HOLD);
        check("bad_sel_scene", scene, 1);
        check("changed_count_all", sc_cnt, 5);

        // Reset in the middle of a fade-out.
        scene_sel = 2'd2;
        frame();
        repeat (4) frame();
        check("pre_rst_fade", fade, 3);
        check("pre_rst_state", dut.state, FADE_OUT);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check("midrst_fade", fade, 7);
        check("midrst_scene", scene, 0);
        check("midrst_phase", phase, 0);
        check("midrst_state", dut.state, HOLD);
        reset = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
